// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
// Optional feature macro: BCD_COUNTDOWN_AUTORELOAD_EN (reload on expiry).
package bcd_timer_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Saturate a raw nibble to a legal BCD digit.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        return (d > DIGIT_MAX) ? DIGIT_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle of the BCD countdown timer.
// Optional feature macro: BCD_COUNTDOWN_AUTORELOAD_EN (no interface change).
interface bcd_countdown_timer_if
    import bcd_timer_pkg::*;
#(
    parameter int unsigned DIGITS = 2
);
    logic                      load;
    logic [DIGIT_W*DIGITS-1:0] load_val;
    logic                      start;
    logic                      pause;
    logic                      tick_en;
    logic [DIGIT_W*DIGITS-1:0] q;
    logic                      busy;
    logic                      done;
    logic                      err;

    modport master (
        output load, load_val, start, pause, tick_en,
        input  q, busy, done, err
    );

    modport slave (
        input  load, load_val, start, pause, tick_en,
        output q, busy, done, err
    );
endinterface

// File: rtl/bcd_countdown_timer_down_digit.sv
// One decade stage of the down-counter: decrement with borrow ripple.
// Optional feature macro: BCD_COUNTDOWN_AUTORELOAD_EN (not used here).
module bcd_down_digit
    import bcd_timer_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               borrow_in,
    output logic [DIGIT_W-1:0] next_digit_c,
    output logic               borrow_out_c
);

    // A zero digit wraps to 9 and passes the borrow up; otherwise it absorbs it.
    always_comb begin
        next_digit_c = digit;
        borrow_out_c = 1'b0;
        if (borrow_in) begin
            if (digit == '0) begin
                next_digit_c = DIGIT_MAX;
                borrow_out_c = 1'b1;
            end else begin
                next_digit_c = digit - DIGIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with load/start/pause and expiry pulse.
// Optional feature macro: BCD_COUNTDOWN_AUTORELOAD_EN -- reload the last
// loaded value on expiry and keep running (unless that value is zero).
module bcd_countdown_timer
    import bcd_timer_pkg::*;
#(
    parameter int unsigned DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_countdown_timer_if.slave  bus
);

    localparam int unsigned Q_W = DIGIT_W * DIGITS;

    state_e         state_q, state_d;
    logic [Q_W-1:0] q_q, q_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [Q_W-1:0] q_dec_c;
    logic [Q_W-1:0] load_clamp_c;
    logic           load_bad_c;
    logic           tick_c;
    logic [DIGITS:0] borrow_c;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    logic [Q_W-1:0] reload_q, reload_d;
`endif

    // A decrement is requested only in RUN when nothing of higher priority is present.
    assign tick_c      = (state_q == RUN) && bus.tick_en && !bus.pause && !bus.load;
    assign borrow_c[0] = tick_c;

    // Borrow chain, digit 0 in the least significant nibble.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_down_digit u_digit (
            .digit        (q_q[g*DIGIT_W +: DIGIT_W]),
            .borrow_in    (borrow_c[g]),
            .next_digit_c (q_dec_c[g*DIGIT_W +: DIGIT_W]),
            .borrow_out_c (borrow_c[g+1])
        );
    end

    // Saturate the preset digit by digit and flag any illegal nibble.
    always_comb begin
        load_clamp_c = '0;
        load_bad_c   = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            load_clamp_c[k*DIGIT_W +: DIGIT_W] = clamp_digit(bus.load_val[k*DIGIT_W +: DIGIT_W]);
            if (bus.load_val[k*DIGIT_W +: DIGIT_W] > DIGIT_MAX) begin
                load_bad_c = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; priority load > pause > start > tick.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        done_d  = 1'b0;
        err_d   = err_q;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
        reload_d = reload_q;
`endif
        if (bus.load) begin
            q_d     = load_clamp_c;
            err_d   = load_bad_c;
            state_d = IDLE;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
            reload_d = load_clamp_c;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.pause) begin
                        if (q_q != '0) begin
                            state_d = RUN;
                        end else begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        state_d = PAUSED;
                    end else if (tick_c && !borrow_c[DIGITS]) begin
                        // borrow out of the top digit would mean counting below zero
                        if (q_q == Q_W'(1)) begin
                            done_d = 1'b1;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
                            if (reload_q != '0) begin
                                q_d = reload_q;
                            end else begin
                                q_d     = '0;
                                state_d = DONE;
                            end
`else
                            q_d     = '0;
                            state_d = DONE;
`endif
                        end else begin
                            q_d = q_dec_c;
                        end
                    end
                end
                PAUSED: begin
                    if (bus.start && !bus.pause) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    if (bus.start && !bus.pause) begin
                        done_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == RUN) || (state_d == PAUSED);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            q_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    // Reload value captured on every load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    assign bus.q    = q_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer (DIGITS=2): directed steps
// followed by random control traffic, checked against a decimal model.
module tb_bcd_countdown_timer;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PAUS = 2;
    localparam int M_DONE = 3;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bcd_countdown_timer_if #(.DIGITS(2)) bus ();

    bcd_countdown_timer #(.DIGITS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model: count kept as a plain decimal integer
    int m_cnt    = 0;
    int m_st     = M_IDLE;
    int m_reload = 0;
    bit m_done   = 1'b0;
    bit m_err    = 1'b0;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_st = M_IDLE; m_reload = 0; m_done = 1'b0; m_err = 1'b0;
    endtask

    task automatic model_step();
        int hi, lo;
        m_done = 1'b0;
        if (bus.load) begin
            lo = int'(bus.load_val[3:0]);
            hi = int'(bus.load_val[7:4]);
            m_err    = (lo > 9) || (hi > 9);
            m_cnt    = (hi > 9 ? 9 : hi) * 10 + (lo > 9 ? 9 : lo);
            m_reload = m_cnt;
            m_st     = M_IDLE;
        end else if (m_st == M_RUN) begin
            if (bus.pause) begin
                m_st = M_PAUS;
            end else if (bus.tick_en) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_done = 1'b1;
                    if (AUTO && m_reload != 0) m_cnt = m_reload;
                    else m_st = M_DONE;
                end
            end
        end else if (bus.start && !bus.pause) begin
            if (m_st == M_IDLE) begin
                if (m_cnt != 0) m_st = M_RUN;
                else begin m_st = M_DONE; m_done = 1'b1; end
            end else if (m_st == M_PAUS) begin
                m_st = M_RUN;
            end else begin
                m_done = 1'b1;
            end
        end
    endtask

    task automatic set_in(input bit l, input logic [7:0] lv, input bit s, input bit p, input bit t);
        bus.load = l; bus.load_val = lv; bus.start = s; bus.pause = p; bus.tick_en = t;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".q"},    32'(bus.q),    32'(to_bcd(m_cnt)));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(m_st == M_RUN || m_st == M_PAUS));
        chk({tag, ".done"}, 32'(bus.done), 32'(m_done));
        chk({tag, ".err"},  32'(bus.err),  32'(m_err));
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        int r;
        logic [7:0] lv;
        reset = 1'b0;
        set_in(0, 8'h00, 0, 0, 0);
        model_reset();
        #12;
        chk("rst_q", 32'(bus.q), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_err", 32'(bus.err), 32'h0);
        @(negedge clk) reset = 1'b1;

        // asynchronous reset while running at 37
        set_in(1, 8'h37, 0, 0, 0); cyc("mr_load");
        set_in(0, 8'h00, 1, 0, 0); cyc("mr_start");
        chk("mr_q37", 32'(bus.q), 32'h37);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("mr_q", 32'(bus.q), 32'h0);
        chk("mr_busy", 32'(bus.busy), 32'h0);
        chk("mr_done", 32'(bus.done), 32'h0);
        set_in(0, 8'h00, 0, 0, 1);
        @(negedge clk) reset = 1'b1;
        cyc("mr_after1");
        cyc("mr_after2");

        // borrow chain 10 -> 00
        set_in(1, 8'h10, 0, 0, 0); cyc("bc_load");
        set_in(0, 8'h00, 1, 0, 0); cyc("bc_start");
        set_in(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 13; i++) cyc("bc_tick");

        // pause and resume
        set_in(1, 8'h05, 0, 0, 0); cyc("pr_load");
        set_in(0, 8'h00, 1, 0, 0); cyc("pr_start");
        set_in(0, 8'h00, 0, 0, 1); cyc("pr_t1"); cyc("pr_t2");
        chk("pr_q03", 32'(bus.q), 32'h03);
        set_in(0, 8'h00, 0, 1, 1);
        for (int i = 0; i < 3; i++) cyc("pr_pause");
        chk("pr_hold03", 32'(bus.q), 32'h03);
        set_in(0, 8'h00, 1, 1, 0); cyc("pr_pause_wins");
        set_in(0, 8'h00, 1, 0, 0); cyc("pr_resume");
        set_in(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc("pr_run");

        // zero load then start; start again in DONE
        set_in(1, 8'h00, 0, 0, 0); cyc("z_load");
        set_in(0, 8'h00, 1, 0, 0); cyc("z_start");
        chk("z_done", 32'(bus.done), 32'h1);
        set_in(0, 8'h00, 0, 0, 1); cyc("z_idle");
        set_in(0, 8'h00, 1, 0, 0); cyc("z_restart");

        // clamping and sticky error
        set_in(1, 8'h1C, 0, 0, 0); cyc("e_load1c");
        chk("e_q19", 32'(bus.q), 32'h19);
        chk("e_err", 32'(bus.err), 32'h1);
        set_in(0, 8'h00, 1, 0, 0); cyc("e_start");
        set_in(1, 8'hA3, 0, 0, 0); cyc("e_loada3");
        set_in(1, 8'h20, 0, 0, 0); cyc("e_load20");
        chk("e_clr", 32'(bus.err), 32'h0);

        // priority: everything at once while running
        set_in(1, 8'h45, 0, 0, 0); cyc("p_load");
        set_in(0, 8'h00, 1, 0, 0); cyc("p_start");
        set_in(0, 8'h00, 0, 0, 1); cyc("p_tick");
        set_in(1, 8'h62, 1, 1, 1); cyc("p_all");
        chk("p_q62", 32'(bus.q), 32'h62);
        set_in(0, 8'h00, 0, 0, 1); cyc("p_idle");

        // short countdown exercising expiry (and reload when enabled)
        set_in(1, 8'h03, 0, 0, 0); cyc("ar_load");
        set_in(0, 8'h00, 1, 0, 0); cyc("ar_start");
        set_in(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 8; i++) cyc("ar_tick");

        // random control traffic
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(99, 0));
            if ($urandom_range(1, 0) == 1) lv = 8'($urandom_range(15, 0));
            else lv = 8'($urandom);
            set_in(r < 4, lv,
                   $urandom_range(99, 0) < 15,
                   $urandom_range(99, 0) < 8,
                   $urandom_range(99, 0) < 75);
            cyc("rnd");
        end

        set_in(0, 8'h00, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Multi-digit BCD down-counter with load, start, pause and terminal-count signalling.
- It is the down-counting counterpart of the team's decade up-counter.
- Used as a programmable countdown/timeout source. Each digit is a 0-9 decade stage; borrow ripples from digit 0 upward.
- Presents BCD digits directly to display and compare logic.

Parameters:
- DIGITS, 2, number of cascaded decade stages; q width = 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- load  input  1  load load_val into q, synchronous
- load_val  input  4*DIGITS  BCD preset value; digit 0 in bits [3:0]
- start  input  1  begin or resume counting
- pause  input  1  suspend counting
- tick_en  input  1  count-enable strobe; one decrement per cycle it is high in RUN
- q  output  4*DIGITS  current BCD count, registered
- busy  output  1  high in RUN or PAUSED
- done  output  1  one-cycle pulse on expiry
- err  output  1  sticky flag: last load contained a non-BCD digit

Behaviour:
- Clock and reset: one clock domain, clk. reset is asynchronous and active-low. While reset=0: q=0, state=IDLE, busy=0, done=0, err=0, reload register=0.
- States: IDLE, RUN, PAUSED, DONE. busy=1 exactly in RUN and PAUSED.
- Priority each cycle: load > pause > start > tick_en.
- load, any state:
  - q and the reload register take load_val; state goes to IDLE; done=0.
  - Any digit >9 is clamped to 9, and err is set for that load.
  - err stays set until the next load that has all digits valid.
- start in IDLE:
  - q!=0: go to RUN next cycle. No decrement happens on the start cycle.
  - q==0: go to DONE, done=1 for one cycle.
- RUN, tick_en=1:
  - BCD decrement by 1, visible on q the next cycle.
  - Digit k at 0 becomes 9 and borrows from digit k+1. Digit k at a non-zero value decrements and stops the borrow.
- RUN, tick_en=0: q holds.
- Expiry: a decrement while q==1 sets q=0, state=DONE and done=1 on that same edge. done is high only in the first cycle q reads 0.
- pause in RUN: go to PAUSED and q holds. A tick_en in the same cycle is ignored.
- start in PAUSED: return to RUN. pause and start together: pause wins.
- DONE: q holds 0. start re-enters DONE logic (done pulses again). load leaves DONE.
- start or pause while already in the target state: no effect.
- Wrap-around: never occurs without the optional feature. q cannot go below 0.
- Latency: one cycle from any control input to the registered output change.
- Reset mid-count: immediate clear. Nothing resumes after reset is released.

Optional Feature:
- Macro: BCD_COUNTDOWN_AUTORELOAD_EN.
- Defined:
  - On expiry, q is reloaded from the reload register instead of going to 0, and state stays RUN.
  - done pulses for one cycle on each expiry; q never reads 0 on that edge.
  - If the reload register is 0, behave as if the macro were undefined (go to DONE).
- Undefined: the behaviour described above. The reload register exists only for the macro build.

Decomposition:
- Package bcd_timer_pkg: state enum (IDLE, RUN, PAUSED, DONE); DIGIT_W=4; DIGIT_MAX=4'd9.
- Sub-module bcd_down_digit, one per digit, generated DIGITS times:
  - Inputs: digit value, borrow_in.
  - Outputs: next value, borrow_out (digit==0 && borrow_in).
  - Top-level FSM drives borrow_in of digit 0 = RUN && tick_en && !pause && !load.

Test Plan:
- Reset: reset low mid-RUN with q=8'h37 -> q=8'h00, busy=0, done=0 immediately, without waiting for a clock edge.
- Borrow chain (DIGITS=2): load 8'h10, start, tick_en held high -> q sequence 10,09,08,...,01,00. done is high only on the 00 cycle; state DONE, busy=0.
- Pause/resume: load 8'h05, start, 2 ticks (q=03), pause with tick_en=1 for 3 cycles -> q stays 03. start -> q 02,01,00, done pulses once.
- Edge inputs: load 8'h00 then start -> done pulses next cycle, busy never 1. load 8'h1C -> q=8'h19, err=1. A later load of 8'h20 clears err.
- Priority: in RUN, load=pause=start=tick_en=1 in one cycle -> q=load_val, IDLE, no decrement.
- Autoreload (macro defined): load 8'h03, start, tick_en high -> q 03,02,01,03,02,... done pulses on each 01->03 edge, busy stays 1.
